// File: rtl/roteador_pkg.sv
// Shared types and constants for the arbitrated N-input packet router.
package roteador_pkg;

    typedef enum logic {OCIOSO, TRANSMITINDO} estado_t;

    localparam logic MODO_FIXO = 1'b0;
    localparam logic MODO_RR   = 1'b1;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin picker: first requesting channel searching upward
// from ptr+1, wrapping modulo N_IN.
module arbitro_rr #(
    parameter int N_IN = 4,
    parameter int SW   = $clog2(N_IN)
) (
    input  logic [N_IN-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [SW-1:0]   winner,
    output logic            found
);

    logic [SW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        // ptr itself is visited last, so the previous owner has lowest priority
        for (int i = 1; i <= N_IN; i++) begin
            idx = SW'((int'(ptr) + i) % N_IN);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/roteador_arbitrado.sv
// N-input packet router: fixed or round-robin selection, packet-level lock,
// single registered output stage.
module roteador_arbitrado
    import roteador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N_IN  = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [N_IN-1:0]           in_valid,
    input  logic [N_IN*WIDTH-1:0]     in_data,
    input  logic [N_IN-1:0]           in_last,
    output logic [N_IN-1:0]           in_ready,
    input  logic                      modo,
    input  logic [$clog2(N_IN)-1:0]   sel,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [$clog2(N_IN)-1:0]   grant,
    output logic                      busy
);

    localparam int SW = $clog2(N_IN);

    estado_t          estado, estado_prox;
    logic [SW-1:0]    ptr, ptr_prox;
    logic [SW-1:0]    grant_prox;
    logic [SW-1:0]    rr_winner;
    logic             rr_found;
    logic             pode_aceitar;
    logic             transfer;
    logic [WIDTH-1:0] canal_data [N_IN];

    for (genvar g = 0; g < N_IN; g++) begin : g_unpack
        assign canal_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    arbitro_rr #(
        .N_IN (N_IN),
        .SW   (SW)
    ) u_arbitro (
        .req    (in_valid),
        .ptr    (ptr),
        .winner (rr_winner),
        .found  (rr_found)
    );

    assign pode_aceitar = !out_valid || out_ready;
    assign busy         = (estado == TRANSMITINDO);

    always_comb begin
        estado_prox = estado;
        grant_prox  = grant;
        ptr_prox    = ptr;
        in_ready    = '0;
        transfer    = 1'b0;
        case (estado)
            OCIOSO: begin
                if (modo == MODO_RR) begin
                    if (rr_found) begin
                        grant_prox  = rr_winner;
                        ptr_prox    = rr_winner;
                        estado_prox = TRANSMITINDO;
                    end
                end else if (in_valid[sel]) begin
                    grant_prox  = sel;
                    estado_prox = TRANSMITINDO;
                end
            end
            TRANSMITINDO: begin
                in_ready[grant] = pode_aceitar;
                transfer        = in_valid[grant] && pode_aceitar;
                if (transfer && in_last[grant]) begin
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
            grant  <= '0;
            ptr    <= SW'(N_IN - 1);
        end else begin
            estado <= estado_prox;
            grant  <= grant_prox;
            ptr    <= ptr_prox;
        end
    end

    // Data/last only change on a load, so they stay stable under backpressure
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= canal_data[grant];
            out_last  <= in_last[grant];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
